// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive stimulus engine for an N_IN-input combinational function.
//   On start it walks stim through 0..2^N_IN-1, holding each code HOLD
//   cycles, samples resp on the last cycle of each hold and compares it to
//   EXPECTED[code]. Reports mismatch count, lowest failing code, pass/fail.
//
//   Optional: define TRUTH_TABLE_SWEEPER_SIG_EN to add a CRC-16 (0x1021,
//   seed FFFF) signature of all sampled responses on output sig.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          launch a sweep (honoured in IDLE / DONE)
//   abort          cancel the running sweep (honoured in DRIVE)
//   resp           response of the function under test
//   stim[N_IN]     registered code to the function under test (MSB = a)
//   busy           sweep in progress
//   done           sweep completed
//   pass           done and no mismatches
//   err_cnt[N_IN+1] mismatches this sweep
//   first_fail     lowest failing code
//   first_fail_vld first_fail holds a captured code
//   sig[16]        response signature (only with TRUTH_TABLE_SWEEPER_SIG_EN)
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int HOLD = 20,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hB2C4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            resp,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
  ,
  output logic [15:0]     sig
`endif
);

  // hold counter needs at least one bit even when HOLD == 1
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] code;
  logic [HW-1:0]   hold;
  logic            hold_end, smp, miss, last;
  logic [N_IN:0]   err_nxt;

  assign hold_end = (hold == HW'(HOLD - 1));
  // abort suppresses the sample on its own edge, including the final one
  assign smp      = (state == DRIVE) && !abort && hold_end;
  assign miss     = smp && (resp != EXPECTED[code]);
  assign last     = (code == {N_IN{1'b1}});
  assign err_nxt  = err_cnt + {{N_IN{1'b0}}, miss};

  assign stim = code;
  assign busy = (state == DRIVE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE: begin
        if (abort)            state_nxt = IDLE;
        else if (smp && last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code           <= '0;
      hold           <= '0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            code           <= '0;
            hold           <= '0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            // partial counts stay visible for debug
            code <= '0;
            hold <= '0;
            pass <= 1'b0;
          end else if (!hold_end) begin
            hold <= hold + 1'b1;
          end else begin
            err_cnt <= err_nxt;
            if (miss && !first_fail_vld) begin
              first_fail     <= code;
              first_fail_vld <= 1'b1;
            end
            if (!last) begin
              code <= code + 1'b1;
              hold <= '0;
            end else begin
              pass <= (err_nxt == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
  logic sig_fb;
  assign sig_fb = sig[15] ^ resp;

  always_ff @(posedge clk) begin
    if (rst)
      sig <= 16'hFFFF;
    else if ((state != DRIVE) && start)
      sig <= 16'hFFFF;
    else if (smp)
      sig <= {sig[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default instance (N_IN=4, HOLD=20, B2C4)
// plus a small XOR instance (N_IN=2, HOLD=1). Expected results come from a
// bench model pushed to a scoreboard at launch and popped at completion,
// abort or reset.
module tb_truth_table_sweeper;

  localparam int N  = 4;
  localparam int H  = 20;
  localparam int NC = 16;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ff;
    logic       ffv;
    logic       pass;
    logic       dn;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  logic       clk = 1'b0;
  logic       rst, start, abort, resp;
  logic [3:0] stim, first_fail;
  logic       busy, done, pass, first_fail_vld;
  logic [4:0] err_cnt;
  int         mode;
  logic [15:0] exp_tt = 16'hB2C4;

  logic       s_start, s_resp, s_busy, s_done, s_pass, s_ffv;
  logic [1:0] s_stim, s_ff;
  logic [2:0] s_err;
  int         s_mode;
  logic [3:0] s_tt = 4'b0110;

`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
  logic [15:0] sig;
  logic [15:0] s_sig;
`endif

  always #5 clk = ~clk;

  // mode 0: correct model, 1: stuck-at-0, 2: stuck-at-1
  assign resp   = (mode == 0) ? exp_tt[stim] : (mode == 2);
  assign s_resp = (s_mode == 0) ? s_tt[s_stim] : 1'b0;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .stim(stim), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld)
`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
    , .sig(sig)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECTED(4'b0110)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .resp(s_resp),
    .stim(s_stim), .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_fail(s_ff), .first_fail_vld(s_ffv)
`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
    , .sig(s_sig)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_resp(input int md, input int k);
    return (md == 0) ? exp_tt[k] : (md == 2);
  endfunction

  task automatic cmp_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("err_cnt", err_cnt, e.err);
    chk("first_fail", first_fail, e.ff);
    chk("first_fail_vld", first_fail_vld, e.ffv);
    chk("pass", pass, e.pass);
    chk("done", done, e.dn);
  endtask

  // One sweep of the default instance. start_c: cycle to pulse start while
  // busy (-1 none). abort_e / rst_e: edge offset from launch at which abort
  // or rst is seen high (0 none).
  task automatic run_sweep(input int md, input int start_c, input int abort_e, input int rst_e);
    exp_t e;
    int   ns, bad, fin;
    logic r;
`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
    logic [15:0] crc;
`endif
    mode = md;
    ns = NC;
    if (abort_e > 0) begin
      ns = 0;
      for (int k = 0; k < NC; k++) if ((k + 1) * H < abort_e) ns++;
    end
    e = '{default: '0};
    for (int k = 0; k < ns; k++) begin
      r = model_resp(md, k);
      if (r != exp_tt[k]) begin
        e.err++;
        if (!e.ffv) begin e.ff = 4'(k); e.ffv = 1'b1; end
      end
    end
    e.dn   = (ns == NC) && (abort_e == 0);
    e.pass = e.dn && (e.err == 0);
    if (rst_e > 0) e = '{default: '0};
    sb.push_back(e);

    fin = (rst_e > 0) ? rst_e : (abort_e > 0) ? abort_e : NC * H;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("clr_err", err_cnt, 0);
    chk("clr_ffv", first_fail_vld, 0);
    bad = 0;
    for (int c = 0; c < fin; c++) begin
      if (busy !== 1'b1 || stim !== 4'(c / H)) bad++;
      start = (c == start_c);
      abort = (c == abort_e - 1);
      rst   = (c == rst_e - 1);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    chk("stim_seq", bad, 0);
    if (rst_e > 0 || abort_e > 0) begin
      chk("stop_busy", busy, 0);
      chk("stop_stim", stim, 0);
    end else begin
      chk("end_busy", busy, 0);
      chk("end_stim", stim, 15);
`ifdef TRUTH_TABLE_SWEEPER_SIG_EN
      crc = 16'hFFFF;
      for (int k = 0; k < NC; k++) begin
        r = crc[15] ^ model_resp(md, k);
        crc = {crc[14:0], 1'b0} ^ (r ? 16'h1021 : 16'h0000);
      end
      chk("sig", sig, crc);
`endif
    end
    cmp_sb();
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    s_start = 1'b0; s_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ffv", first_fail_vld, 0);
    chk("rst_pass", pass, 0);

    // correct model, with a start pulse mid-sweep that must be ignored
    run_sweep(0, 50, 0, 0);
    repeat (10) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_stim", stim, 15);
    chk("hold_pass", pass, 1);

    run_sweep(1, -1, 0, 0);          // stuck-at-0: 7 errors, first 2
    run_sweep(2, -1, 0, 0);          // stuck-at-1: 9 errors, first 0
    run_sweep(0, -1, 0, 0);          // relaunch from DONE clears counts
    run_sweep(1, -1, 141, 0);        // abort after code 6 sampled
    run_sweep(1, -1, 140, 0);        // abort on a sample edge: no sample
    run_sweep(1, -1, NC * H, 0);     // abort beats the final sample
    run_sweep(1, -1, 0, 150);        // reset mid-sweep
    chk("rst_ff", first_fail, 0);

    // small XOR instance, HOLD=1
    s_mode = 0;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (s_busy !== 1'b1 || s_stim !== 2'(c)) bad++;
      @(negedge clk);
    end
    chk("s_stim_seq", bad, 0);
    chk("s_done", s_done, 1);
    chk("s_pass", s_pass, 1);
    chk("s_err", s_err, 0);
    s_mode = 1;
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("s0_done", s_done, 1);
    chk("s0_err", s_err, 2);
    chk("s0_ff", s_ff, 1);
    chk("s0_pass", s_pass, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
